// File: rtl/coder_move_ctrl.sv
// Closed-loop point-to-point move sequencer driven by the encoder position count.
// Drive/status outputs are registered with the state; commands are taken only in IDLE.
module coder_move_ctrl #(
    parameter int unsigned CLK_DIV    = 80,
    parameter int unsigned SLOW_ZONE  = 100,
    parameter int unsigned WINDOW     = 2,
    parameter int unsigned SETTLE_US  = 5000,
    parameter int unsigned TIMEOUT_MS = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_target,
    input  logic        cmd_abort,
    input  logic [15:0] pco,
    output logic        drv_en,
    output logic        drv_dir,
    output logic        drv_fast,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] pos_err
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned MW = $clog2(TIMEOUT_MS + 1);
    localparam int unsigned SW = $clog2(SETTLE_US + 1);

    localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
    localparam logic [9:0]    US_LAST  = 10'd999;
    localparam logic [MW-1:0] MS_LAST  = MW'(TIMEOUT_MS - 1);
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_US - 1);
    localparam logic [16:0]   SLOW_LIM = 17'(SLOW_ZONE);
    localparam logic [16:0]   WIN_LIM  = 17'(WINDOW);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN_FAST = 3'd1,
        RUN_SLOW = 3'd2,
        SETTLE   = 3'd3,
        DONE     = 3'd4,
        FAULT    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   target_q;
    logic [PW-1:0] pdiv_q, pdiv_d;
    logic [9:0]    us_in_ms_q, us_in_ms_d;
    logic [MW-1:0] ms_cnt_q, ms_cnt_d;
    logic [PW-1:0] sdiv_q, sdiv_d;
    logic [SW-1:0] sus_q, sus_d;
    logic          drv_en_q, drv_en_d;
    logic          drv_dir_q, drv_dir_d;
    logic          drv_fast_q, drv_fast_d;
    logic          done_q, err_q;
    logic [1:0]    err_code_q, err_code_d;
    logic [15:0]   pos_err_q;

    logic [15:0]   cur_diff, cmd_diff;
    logic [16:0]   cur_mag, cmd_mag;
    logic          accept, us_tick, ms_tick, ms_expire, settle_tick, settle_done, drive;

    // |d| in 17 bits so that 0x8000 reads as 32768 rather than wrapping negative.
    function automatic logic [16:0] mag(input logic [15:0] d);
        return d[15] ? (17'h10000 - {1'b0, d}) : {1'b0, d};
    endfunction

    function automatic logic ahead(input logic [15:0] d);
        return !d[15] && (d != 16'd0);
    endfunction

    assign cur_diff    = target_q - pco;
    assign cmd_diff    = cmd_target - pco;
    assign cur_mag     = mag(cur_diff);
    assign cmd_mag     = mag(cmd_diff);
    assign cmd_ready   = (state_q == IDLE);
    assign accept      = cmd_valid && cmd_ready && !cmd_abort;
    assign us_tick     = (state_q != IDLE) && (pdiv_q == DIV_LAST);
    assign ms_tick     = us_tick && (us_in_ms_q == US_LAST);
    assign ms_expire   = ms_tick && (ms_cnt_q == MS_LAST);
    assign settle_tick = (sdiv_q == DIV_LAST);
    assign settle_done = (state_q == SETTLE) && settle_tick && (sus_q == SET_LAST);

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_code_d = 2'b00;
                    if (cmd_mag <= WIN_LIM)      state_d = DONE;
                    else if (cmd_mag > SLOW_LIM) state_d = RUN_FAST;
                    else                         state_d = RUN_SLOW;
                end
            end
            RUN_FAST, RUN_SLOW, SETTLE: begin
                if (cmd_abort) begin
                    state_d    = FAULT;
                    err_code_d = 2'b10;
                end else if (ms_expire) begin
                    state_d    = FAULT;
                    err_code_d = 2'b01;
                end else if (state_q == RUN_FAST) begin
                    // A sign flip against the committed direction means we overshot.
                    if ((cur_mag <= SLOW_LIM) || (ahead(cur_diff) != drv_dir_q))
                        state_d = RUN_SLOW;
                end else if (state_q == RUN_SLOW) begin
                    if (cur_mag <= WIN_LIM) state_d = SETTLE;
                end else begin
                    if (cur_mag > WIN_LIM) state_d = RUN_SLOW;
                    else if (settle_done)  state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        drive      = (state_d == RUN_FAST) || (state_d == RUN_SLOW);
        drv_en_d   = drive;
        drv_fast_d = (state_d == RUN_FAST);
        drv_dir_d  = drv_dir_q;
        if (drive) drv_dir_d = (state_q == IDLE) ? ahead(cmd_diff) : ahead(cur_diff);
    end

    always_comb begin
        pdiv_d     = pdiv_q;
        us_in_ms_d = us_in_ms_q;
        ms_cnt_d   = ms_cnt_q;
        if (accept) begin
            pdiv_d     = '0;
            us_in_ms_d = '0;
            ms_cnt_d   = '0;
        end else if (state_q != IDLE) begin
            pdiv_d = us_tick ? '0 : pdiv_q + 1'b1;
            if (us_tick) us_in_ms_d = ms_tick ? '0 : us_in_ms_q + 1'b1;
            if (ms_tick) ms_cnt_d = ms_cnt_q + 1'b1;
        end

        // Settle timing has its own prescaler so the dwell is exact from SETTLE entry.
        sdiv_d = '0;
        sus_d  = '0;
        if ((state_q == SETTLE) && (state_d == SETTLE)) begin
            sdiv_d = settle_tick ? '0 : sdiv_q + 1'b1;
            sus_d  = settle_tick ? sus_q + 1'b1 : sus_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            target_q   <= '0;
            pdiv_q     <= '0;
            us_in_ms_q <= '0;
            ms_cnt_q   <= '0;
            sdiv_q     <= '0;
            sus_q      <= '0;
            drv_en_q   <= 1'b0;
            drv_dir_q  <= 1'b0;
            drv_fast_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            pos_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            if (accept) target_q <= cmd_target;
            pdiv_q     <= pdiv_d;
            us_in_ms_q <= us_in_ms_d;
            ms_cnt_q   <= ms_cnt_d;
            sdiv_q     <= sdiv_d;
            sus_q      <= sus_d;
            drv_en_q   <= drv_en_d;
            drv_dir_q  <= drv_dir_d;
            drv_fast_q <= drv_fast_d;
            done_q     <= (state_d == DONE);
            err_q      <= (state_d == FAULT);
            err_code_q <= err_code_d;
            pos_err_q  <= cur_diff;
        end
    end

    assign drv_en   = drv_en_q;
    assign drv_dir  = drv_dir_q;
    assign drv_fast = drv_fast_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign pos_err  = pos_err_q;

endmodule

// File: tb/tb_coder_move_ctrl.sv
// Directed bench for coder_move_ctrl with shortened timing (2 clk/us, 10 us settle, 4 ms timeout).
module tb_coder_move_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_target;
    logic        cmd_abort;
    logic [15:0] pco;
    logic        drv_en, drv_dir, drv_fast, busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] pos_err;

    int checks   = 0;
    int failures = 0;
    int saw_fast, slow_pco, drop_pco, settle_len, fin, n;

    coder_move_ctrl #(
        .CLK_DIV(2), .SLOW_ZONE(100), .WINDOW(2), .SETTLE_US(10), .TIMEOUT_MS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_abort(cmd_abort), .pco(pco),
        .drv_en(drv_en), .drv_dir(drv_dir), .drv_fast(drv_fast), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .pos_err(pos_err)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] tgt);
        cmd_target = tgt;
        cmd_valid  = 1'b1;
        cyc(1);
        cmd_valid  = 1'b0;
    endtask

    // Motor model: pco steps one count toward drv_dir every 'period' cycles while enabled.
    task automatic motor(input int period, input int budget);
        int tmr;
        int drop_c;
        tmr = 0; drop_c = 0;
        saw_fast = 0; slow_pco = -1; drop_pco = -1; settle_len = -1; fin = 0;
        for (int c = 0; c < budget; c++) begin
            if (drv_fast) saw_fast = 1;
            if (drv_en && !drv_fast && saw_fast == 1 && slow_pco < 0) slow_pco = int'(pco);
            if (!drv_en && drop_pco < 0) begin
                drop_pco = int'(pco);
                drop_c   = c;
            end
            if (done) begin
                fin = 1;
                settle_len = c - drop_c;
                break;
            end
            if (err) break;
            if (drv_en) begin
                tmr++;
                if (tmr == period) begin
                    tmr = 0;
                    pco = drv_dir ? pco + 16'd1 : pco - 16'd1;
                end
            end
            cyc(1);
        end
    endtask

    task automatic wait_done(input int budget, output int cnt);
        cnt = -1;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                cnt = c;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic wait_err(input int budget, output int cnt);
        cnt = -1;
        for (int c = 0; c < budget; c++) begin
            if (err) begin
                cnt = c;
                break;
            end
            cyc(1);
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_target = 16'd0; cmd_abort = 1'b0; pco = 16'd0;
        cyc(3);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_en", drv_en, 0);
        chk("rst_done_err", {done, err, err_code}, 0);
        chk("rst_poserr", pos_err, 0);
        rst_n = 1'b1;
        cyc(1);

        // 1: long forward move, fast then slow, exact settle dwell
        pco = 16'd0;
        start(16'd500);
        chk("t1_accept_drive", {drv_en, drv_fast, drv_dir, busy}, 4'b1111);
        chk("t1_ready_low", cmd_ready, 0);
        motor(10, 7000);
        chk("t1_fast_seen", saw_fast, 1);
        chk("t1_slow_at", slow_pco, 400);
        chk("t1_en_drop_at", drop_pco, 498);
        chk("t1_done", fin, 1);
        chk("t1_settle_cycles", settle_len, 20);
        chk("t1_done_err", err, 0);
        chk("t1_poserr", pos_err, 16'd2);
        cyc(1);
        chk("t1_idle", {done, busy, cmd_ready}, 3'b001);

        // already in window: straight to DONE without driving
        start(16'd499);
        chk("win_done", {done, drv_en, busy}, 3'b101);
        cyc(1);

        // 2: wrap across 0xFFFF, short move runs slow only
        pco = 16'hFFF0;
        start(16'h0010);
        chk("t2_drive", {drv_en, drv_fast, drv_dir}, 3'b101);
        motor(2, 500);
        chk("t2_no_fast", saw_fast, 0);
        chk("t2_en_drop_at", drop_pco, 32'h000E);
        chk("t2_done", fin, 1);
        cyc(1);

        // 3: overshoot in RUN_FAST
        pco = 16'd0;
        start(16'd1000);
        cyc(3);
        chk("t3_fast", {drv_en, drv_fast, drv_dir}, 3'b111);
        pco = 16'd1050;
        cyc(1);
        chk("t3_slow_rev", {drv_en, drv_fast, drv_dir}, 3'b100);
        chk("t3_poserr", pos_err, 16'hFFCE);
        motor(1, 500);
        chk("t3_en_drop_at", drop_pco, 1002);
        chk("t3_done", fin, 1);
        chk("t3_settle_cycles", settle_len, 20);
        cyc(1);

        // 4: disturbance during SETTLE restarts the dwell
        pco = 16'd190;
        start(16'd200);
        chk("t4_slow", {drv_en, drv_fast, drv_dir}, 3'b101);
        pco = 16'd200;
        cyc(1);
        chk("t4_settle", {drv_en, busy}, 2'b01);
        cyc(7);
        pco = 16'd205;
        cyc(1);
        chk("t4_reslow", {drv_en, drv_fast, drv_dir}, 3'b100);
        pco = 16'd200;
        cyc(1);
        chk("t4_settle2", {drv_en, done}, 2'b00);
        wait_done(100, n);
        chk("t4_settle_restart", n, 20);
        cyc(1);

        // 5: frozen encoder times out 4 ms (8000 clk) after accept
        pco = 16'd0;
        start(16'd1000);
        wait_err(8100, n);
        chk("t5_timeout_cycles", n, 8000);
        chk("t5_code", err_code, 2'b01);
        chk("t5_en", {drv_en, done}, 2'b00);
        cyc(1);
        chk("t5_idle", {err, busy, err_code}, 4'b0001);

        // 6: busy ignores cmd_valid, abort faults, abort blocks accept, reset mid-move
        start(16'd1000);
        cmd_valid = 1'b1; cmd_target = 16'd5;
        cyc(2);
        cmd_valid = 1'b0;
        chk("t6_ignore_valid", {busy, drv_fast, drv_en}, 3'b111);
        chk("t6_target_kept", pos_err, 16'd1000);
        cmd_abort = 1'b1;
        cyc(1);
        cmd_abort = 1'b0;
        chk("t6_abort", {err, drv_en, err_code}, 4'b1010);
        cyc(1);
        chk("t6_after_abort", {err, busy, cmd_ready}, 3'b001);
        cmd_valid = 1'b1; cmd_abort = 1'b1; cmd_target = 16'd1000;
        cyc(1);
        cmd_valid = 1'b0; cmd_abort = 1'b0;
        chk("t6_abort_blocks", {busy, drv_en, err, err_code}, 5'b00010);
        start(16'd1000);
        cyc(2);
        chk("t6_moving", {drv_en, busy}, 2'b11);
        rst_n = 1'b0;
        cyc(1);
        chk("t6_reset_drive", {drv_en, drv_fast, drv_dir, busy}, 0);
        chk("t6_reset_status", {done, err, err_code, cmd_ready}, 5'b00001);
        chk("t6_reset_poserr", pos_err, 0);
        rst_n = 1'b1;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
